// File: rtl/bin_bcd_seg_driver.sv
// 8-bit binary to 3-digit BCD converter (shift-and-add-3) with a
// time-multiplexed, common-anode seven-segment scan driver.
module bin_bcd_seg_driver #(
  parameter int SCAN_DIV      = 16,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  bin,
  input  logic        load,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  // state | meaning
  // IDLE  | waiting for load; bcd holds last result
  // CONV  | one double-dabble shift per cycle, 8 in total
  typedef enum logic {IDLE, CONV} state_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);

  state_t      state;
  logic [7:0]  shreg;
  logic [11:0] scratch;
  logic [2:0]  shcnt;
  logic [11:0] adj;
  logic [19:0] shifted;

  logic [15:0] scan_cnt;
  logic [1:0]  digit;
  logic [3:0]  nib;
  logic        blank;

  always_comb begin
    adj = scratch;
    for (int i = 0; i < 3; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
  end

  assign shifted = {adj[10:0], shreg, 1'b0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= 12'h000;
      shreg   <= 8'h00;
      scratch <= 12'h000;
      shcnt   <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shreg   <= bin;
            scratch <= 12'h000;
            shcnt   <= 3'd0;
            busy    <= 1'b1;
            state   <= CONV;
          end
        end
        CONV: begin
          scratch <= shifted[19:8];
          shreg   <= shifted[7:0];
          shcnt   <= shcnt + 3'd1;
          if (shcnt == 3'd7) begin
            bcd   <= shifted[19:8];
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= 16'd0;
      digit    <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= 16'd0;
      digit    <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  // Display path reads only registered state, so bcd updates show immediately.
  always_comb begin
    nib   = bcd[3:0];
    an    = 3'b110;
    blank = 1'b0;
    case (digit)
      2'd1: begin
        nib   = bcd[7:4];
        an    = 3'b101;
        blank = BLANK_LEADING && (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
      end
      2'd2: begin
        nib   = bcd[11:8];
        an    = 3'b011;
        blank = BLANK_LEADING && (bcd[11:8] == 4'd0);
      end
      default: ;
    endcase
  end

  always_comb begin
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
    if (blank)
      seg = 7'b1111111;
  end

endmodule

// File: tb/tb_bin_bcd_seg_driver.sv
// Randomized self-checking bench for bin_bcd_seg_driver against an
// arithmetic decimal/segment model.
module tb_bin_bcd_seg_driver;
  localparam int SCAN = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  bin;
  logic        load;
  logic        busy, done;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  an;

  int checks   = 0;
  int failures = 0;
  int ecount;
  int model_v  = 0;

  bin_bcd_seg_driver #(.SCAN_DIV(SCAN), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .bin(bin), .load(load),
    .busy(busy), .done(done), .bcd(bcd), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;
      2: return 7'b0100100;  3: return 7'b0110000;
      4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;
      8: return 7'b0000000;  9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic start_load(input logic [7:0] v);
    @(negedge clk);
    bin  = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    bin  = 8'($urandom);
  endtask

  task automatic test_reset;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || an !== 3'b110 || seg !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_init busy=%b done=%b bcd=%h an=%b seg=%b", busy, done, bcd, an, seg);
    end
    start_load(8'd123);
    repeat (12) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000 || an !== 3'b110 || seg !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_async busy=%b done=%b bcd=%h an=%b seg=%b required 0 0 000 110 1000000",
               busy, done, bcd, an, seg);
    end
    @(negedge clk);
    rst = 1'b0;
    model_v = 0;
  endtask

  task automatic test_value(input logic [7:0] v);
    start_load(v);
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL accept_%0d busy=%b done=%b required 1 0", v, busy, done);
    end
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      bin = 8'($urandom);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL conv_%0d_cyc%0d busy=%b done=%b required 1 0", v, j, busy, done);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || bcd !== to_bcd(int'(v))) begin
      failures++;
      $display("FAIL done_%0d done=%b busy=%b bcd=%h required 1 0 %h", v, done, busy, bcd, to_bcd(int'(v)));
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL done_drop_%0d done=%b required 0", v, done);
    end
    model_v = int'(v);
  endtask

  task automatic test_display(input int ncyc);
    for (int j = 0; j < ncyc; j++) begin
      int idx, d;
      logic blk;
      logic [2:0] ean;
      logic [6:0] eseg;
      @(negedge clk);
      idx  = (ecount / SCAN) % 3;
      ean  = 3'b111 & ~(3'b001 << idx);
      d    = (idx == 0) ? model_v % 10 : (idx == 1) ? (model_v / 10) % 10 : model_v / 100;
      blk  = (idx == 2) ? (model_v < 100) : (idx == 1) ? (model_v < 10) : 1'b0;
      eseg = blk ? 7'b1111111 : seg_of(d);
      checks++;
      if (an !== ean || seg !== eseg) begin
        failures++;
        $display("FAIL display_v%0d an=%b seg=%b required %b %b", model_v, an, seg, ean, eseg);
      end
    end
  endtask

  task automatic test_busy_ignore;
    int ndone = 0, dpos = 0;
    start_load(8'd255);
    for (int j = 1; j <= 15; j++) begin
      @(negedge clk);
      if (done) begin ndone++; dpos = j; end
      load = (j == 2);
      if (j == 2) bin = 8'd7;
    end
    checks++;
    if (ndone != 1 || dpos != 8) begin
      failures++;
      $display("FAIL busy_ignore_done count=%0d pos=%0d required 1 8", ndone, dpos);
    end
    checks++;
    if (bcd !== 12'h255) begin
      failures++;
      $display("FAIL busy_ignore_bcd bcd=%h required 255", bcd);
    end
    model_v = 255;
  endtask

  task automatic test_back_to_back;
    start_load(8'd42);
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 || bcd !== 12'h042) begin
      failures++;
      $display("FAIL b2b_first done=%b bcd=%h required 1 042", done, bcd);
    end
    bin  = 8'd199;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0 || bcd !== 12'h042) begin
      failures++;
      $display("FAIL b2b_accept busy=%b done=%b bcd=%h required 1 0 042", busy, done, bcd);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (done !== 1'b1 || bcd !== 12'h199) begin
      failures++;
      $display("FAIL b2b_second done=%b bcd=%h required 1 199", done, bcd);
    end
    model_v = 199;
  endtask

  task automatic test_mid_reset;
    int ndone = 0;
    start_load(8'd200);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || bcd !== 12'h000) begin
      failures++;
      $display("FAIL midrst_abort busy=%b bcd=%h required 0 000", busy, bcd);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0 || bcd !== 12'h000) begin
      failures++;
      $display("FAIL midrst_nodone count=%0d bcd=%h required 0 000", ndone, bcd);
    end
    model_v = 0;
    test_value(8'd9);
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++) begin
      test_value(8'($urandom_range(0, 255)));
      test_display(12);
    end
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    bin  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_value(8'd5);
    test_display(12);
    test_busy_ignore;
    test_display(12);
    test_value(8'd100);
    test_display(24);
    test_back_to_back;
    test_display(12);
    test_mid_reset;
    test_display(12);
    test_value(8'd0);
    test_display(12);
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bin_bcd_seg_driver.md
# bin_bcd_seg_driver

Sequential binary-to-BCD converter with a three-digit, time-multiplexed seven-segment driver. It sits downstream of `bin2dec` in the memory/debug display path. It takes the same 8-bit binary value, converts it with a shift-and-add-3 (double-dabble) FSM into hundreds/tens/ones BCD, and scans the held result onto a common-anode display.

## Interface
- `SCAN_DIV`, default 16: clock cycles each digit stays lit; legal range 2..65535.
- `BLANK_LEADING`, default 1: 1 blanks leading zeros, 0 shows all three digits.

- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `bin`  in  8  unsigned binary value; sampled only when a load is accepted.
- `load`  in  1  start-conversion request; accepted only in IDLE.
- `busy`  out  1  high while a conversion is in progress.
- `done`  out  1  one-cycle pulse; `bcd` has just been updated.
- `bcd`  out  12  held result: [11:8] hundreds, [7:4] tens, [3:0] ones.
- `seg`  out  7  active-low segments, bit order g,f,e,d,c,b,a (bit 6 = g).
- `an`  out  3  active-low one-hot digit enable: bit 0 ones, bit 1 tens, bit 2 hundreds.

## Operation
- The FSM has two states, IDLE and CONV.
- **IDLE, load=1:** capture `bin` into the shift register and clear the 12-bit scratch BCD. Clear the shift counter and go to CONV.
- **IDLE, load=0:** stay in IDLE.
- **CONV, each cycle:** for each scratch nibble, add 3 if it is >=5. Then shift {scratch, shift register} left by one. Increment the counter.
- **CONV, 8th shift:** write the result into `bcd`, pulse `done`, and return to IDLE.
- `load` while in CONV is ignored. No queuing; the in-flight conversion is unaffected.
- `bin` changes during CONV have no effect.
- `bcd` holds its value between conversions and is never partially updated.
- Arithmetic: nibble compare/add is 4-bit. With 8-bit input the hundreds digit is at most 2, so no overflow is possible.
- **Scan:** a counter runs 0..SCAN_DIV-1 continuously, independent of the FSM. When it wraps, the digit index advances ones -> tens -> hundreds -> ones.
- `an` is the active-low one-hot of the digit index. `seg` is the decode of the indexed `bcd` nibble:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- **Blanking (BLANK_LEADING=1):**
  - Hundreds is blanked when it is 0.
  - Tens is blanked when hundreds and tens are both 0.
  - Ones is never blanked.
  - A blanked digit drives `seg` = 1111111; its `an` stays active.
- `seg` and `an` are combinational decodes of registered state only; there is no path from `bin` or `load`.

## Timing
- **Reset values:** state IDLE, `busy`=0, `done`=0, `bcd`=12'h000, scan counter 0, digit index ones. This gives `an`=110 and `seg`=1000000.
- **Reset mid-conversion:** the conversion is aborted, `bcd` returns to 0 and no `done` pulse is issued.
- **Latency:** with load accepted at edge k, `busy`=1 from edge k and the shifts occur at edges k+1..k+8.
  - At edge k+8, `bcd` updates, `done` goes 1 and `busy` goes 0.
  - `done` drops at edge k+9.
- **Back-to-back:** a `load` sampled at edge k+9 (the `done` cycle) is accepted, giving a 9-cycle minimum issue interval.
- **Simultaneous events:** scan wrap and `bcd` update on the same edge is legal. The new digit shows the new value immediately.
- **Scan period:** 3*SCAN_DIV cycles. Each `an` value persists for exactly SCAN_DIV cycles.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> outputs take their reset values without waiting for a clock edge: `busy`=0, `done`=0, `bcd`=000, `an`=110, `seg`=1000000.
- **Value 5:** `bin`=8'd5, one-cycle `load` -> `busy` for 8 cycles, `done` pulses 8 edges after acceptance, `bcd`=12'h005.
- **Display of 5:** with BLANK_LEADING=1, the hundreds and tens slots show 1111111 and the ones slot shows 0010010.
- **Value 255 with busy ignore:** `bin`=8'd255 -> `bcd`=12'h255. A `load` with `bin`=8'd7 at cycle 3 of the conversion is ignored, and exactly one `done` pulse occurs.
- **Value 100 blanking:** `bin`=8'd100 -> `bcd`=12'h100. Scanning with SCAN_DIV=4 shows ones 1000000 (4 cycles), tens 1000000 (not blanked), then hundreds 1111001, repeating every 12 cycles.
- **Back-to-back:** load 8'd42, then load 8'd199 in the `done` cycle -> `bcd`=042 after the first `done` and 199 exactly 9 cycles later.
- **Reset mid-conversion:** `rst` at cycle 4 of a conversion of 8'd200 -> no `done`, `bcd`=000. A later load of 8'd9 gives 009.
